// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between
// instruction fetch and data load/store, with ack timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iDone,
  output logic [31:0] iRdata,
  input  logic        dRead,
  input  logic        dWrite,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        dDone,
  output logic [31:0] dRdata,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        busErr,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_t      st, st_n;
  logic        i_pend, i_pend_n;
  logic [31:0] i_addr_q, i_addr_n;
  logic        d_pend, d_pend_n;
  logic        d_we_q, d_we_n;
  logic [31:0] d_addr_q, d_addr_n;
  logic [31:0] d_wdata_q, d_wdata_n;
  // owner of the current access; doubles as last grant (1 = D)
  logic        own_d, own_d_n;
  logic [7:0]  cnt, cnt_n;
  logic        req_n, we_n, idone_n, ddone_n;
  logic        err_n, ovr_n;
  logic [31:0] addr_n, wdata_n;
  logic [31:0] irdata_n, drdata_n, rd_v;
  logic        d_req, i_eff, d_eff;
  logic        gnt_i, gnt_d;

  // next-state, capture, arbitration and output decode
  always_comb begin
    d_req     = dRead | dWrite;
    i_eff     = i_pend | iReq;
    d_eff     = d_pend | d_req;
    i_addr_n  = iReq ? iAddr : i_addr_q;
    d_addr_n  = d_req ? dAddr : d_addr_q;
    d_we_n    = d_req ? dWrite : d_we_q;
    d_wdata_n = dWrite ? dWdata : d_wdata_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    st_n      = st;
    own_d_n   = own_d;
    cnt_n     = cnt;
    req_n     = memReq;
    we_n      = memWe;
    addr_n    = memAddr;
    wdata_n   = memWdata;
    irdata_n  = iRdata;
    drdata_n  = dRdata;
    idone_n   = 1'b0;
    ddone_n   = 1'b0;
    err_n     = busErr;
    rd_v      = memAck ? memRdata : 32'h0;
    ovr_n     = overrun
              | (iReq & i_pend)
              | (d_req & d_pend)
              | (dRead & dWrite);
    unique case (st)
      IDLE: begin
        gnt_i = i_eff & (~d_eff | own_d);
        gnt_d = d_eff & ~gnt_i;
        if (gnt_i | gnt_d) begin
          st_n    = BUSY;
          own_d_n = gnt_d;
          req_n   = 1'b1;
          we_n    = gnt_d & d_we_n;
          addr_n  = gnt_d ? d_addr_n : i_addr_n;
          cnt_n   = '0;
          if (gnt_d) wdata_n = d_wdata_n;
        end
      end
      BUSY: begin
        if (memAck || cnt == CntLast) begin
          st_n    = RESP;
          req_n   = 1'b0;
          idone_n = ~own_d;
          ddone_n = own_d;
          err_n   = busErr | ~memAck;
          if (!memWe) begin
            if (own_d) drdata_n = rd_v;
            else       irdata_n = rd_v;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      RESP:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
    i_pend_n = ~gnt_i & i_eff;
    d_pend_n = ~gnt_d & d_eff;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      i_pend    <= 1'b0;
      i_addr_q  <= '0;
      d_pend    <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      own_d     <= 1'b1;
      cnt       <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      iRdata    <= '0;
      dRdata    <= '0;
      iDone     <= 1'b0;
      dDone     <= 1'b0;
      busErr    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      st        <= st_n;
      i_pend    <= i_pend_n;
      i_addr_q  <= i_addr_n;
      d_pend    <= d_pend_n;
      d_we_q    <= d_we_n;
      d_addr_q  <= d_addr_n;
      d_wdata_q <= d_wdata_n;
      own_d     <= own_d_n;
      cnt       <= cnt_n;
      memReq    <= req_n;
      memWe     <= we_n;
      memAddr   <= addr_n;
      memWdata  <= wdata_n;
      iRdata    <= irdata_n;
      dRdata    <= drdata_n;
      iDone     <= idone_n;
      dDone     <= ddone_n;
      busErr    <= err_n;
      overrun   <= ovr_n;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one word-wide memory between the instruction-fetch requester and the data requester (the core's MemRead/MemWrite strobes). Single-cycle request pulses are captured into per-port pending flags and granted round-robin. Each granted access is sequenced through a memory request/acknowledge handshake, guarded by a timeout. On completion, a one-cycle done pulse and read data are returned to the owning port.

## Interface
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without memAck before abort; legal range 1..255.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: synchronous and active-high.
- iReq  in  1  one-cycle pulse: instruction fetch request.
- iAddr  in  32  fetch address; sampled in the iReq cycle.
- iDone  out  1  one-cycle pulse: fetch complete.
- iRdata  out  32  fetched word; valid from the iDone cycle and held until the next fetch completes.
- dRead  in  1  one-cycle pulse: data load request.
- dWrite  in  1  one-cycle pulse: data store request.
- dAddr  in  32  data address; sampled in the request cycle.
- dWdata  in  32  store data; sampled in the dWrite cycle.
- dDone  out  1  one-cycle pulse: data access complete.
- dRdata  out  32  loaded word; valid from the dDone cycle and held. Unchanged by stores.
- memReq  out  1  memory request; held high until memAck or timeout.
- memWe  out  1  1 = write, 0 = read; stable while memReq is high.
- memAddr  out  32  memory address; stable while memReq is high.
- memWdata  out  32  memory write data; stable while memReq is high.
- memRdata  in  32  memory read data; valid in the memAck cycle.
- memAck  in  1  memory acknowledge; ignored unless memReq is high.
- busErr  out  1  sticky: a timeout abort occurred.
- overrun  out  1  sticky: a request arrived on a port whose pending flag was already set, or dRead and dWrite were high together.

## Operation
- Pending capture:
  - A request pulse sets that port's pending flag and latches its address (and data and write flag for the D port).
  - The flag clears when the port is granted.
  - A new pulse on an already-pending port sets overrun. The new request overwrites the latched fields, so only one request is retained per port.
  - dRead and dWrite high together: treated as a write; overrun is set.
- Effective request per port = pending flag OR the request pulse in the current cycle. This gives a bypass, so a pulse arriving in IDLE is granted in the same cycle.
- Arbitration (IDLE only):
  - If exactly one port has an effective request, grant it.
  - If both do, grant the port not granted last.
  - lastGrant resets to D, so the first tie after reset goes to I.
- State machine:
  - IDLE: on grant, load owner, memWe, memAddr and memWdata into output registers, clear the timeout counter, and go to BUSY.
  - BUSY: memReq = 1.
    - On memAck: capture memRdata into the owner's rdata register (reads only) and go to RESP.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES - 1 without memAck, set busErr, load the owner's rdata register with 32'h0 (reads only) and go to RESP.
  - RESP: pulse the owner's done for exactly one cycle, then go to IDLE.
- Only one transaction is outstanding at any time. Requests arriving during BUSY or RESP are captured as pending and served in later IDLE cycles.
- Reset:
  - All state returns to IDLE and both pending flags clear.
  - memReq, memWe, iDone, dDone, busErr and overrun go to 0.
  - memAddr, memWdata, iRdata, dRdata and lastGrant (to D) reset to their stated values; the registers go to 32'h0.
  - Reset mid-transaction abandons the access with no done pulse; memReq is 0 in the cycle after the reset edge.

## Timing
- All outputs are registered.
- Request pulse at cycle t in IDLE, with memAck at cycle t+1+k (k ≥ 0 wait cycles):
  - memReq is high in cycles t+1 .. t+1+k.
  - done is high at t+2+k.
  - The arbiter is back in IDLE at t+3+k.
- Minimum latency: request at t gives done at t+2. Minimum spacing between back-to-back grants is 3 cycles.
- Timeout: memReq is high for exactly TIMEOUT_CYCLES cycles, then done pulses on the next cycle.
- memAck and the timeout threshold in the same cycle: memAck wins and busErr is not set.
- memAck while memReq is low is ignored.
- Pending requests are served in IDLE with no extra cycle beyond the bypass case.

## Test plan
- Read, zero wait: dRead at t, dAddr=0x10010000, memAck tied 1, memRdata=0xCAFEF00D.
  - memReq is high only at t+1 with memWe=0 and memAddr=0x10010000.
  - dDone is high at t+2 and dRdata=0xCAFEF00D.
- Write with 3 wait cycles: dWrite at t, dWdata=0x12345678.
  - memReq is high t+1..t+4 with memWe=1 and memWdata=0x12345678.
  - memAck at t+4; dDone at t+5; dRdata unchanged.
- Tie then round-robin:
  - iReq and dRead at t after reset: I is served first (iDone at t+2), then D (memReq at t+4, dDone at t+5).
  - Repeat the tie: D is served first.
- Timeout: TIMEOUT_CYCLES=4, memAck held 0, iReq at t.
  - memReq is high t+1..t+4.
  - iDone at t+5, iRdata=0, busErr stays 1.
- Overrun and reset mid-op:
  - Two dRead pulses while a fetch is BUSY: overrun=1 and exactly one D access is later performed.
  - rst asserted in BUSY: memReq=0 the next cycle, no done pulses, all flags 0.
